// File: rtl/otter_muldiv_pkg.sv
// otter_muldiv_pkg: shared types and helpers for the
// iterative RV32M multiply/divide unit.
package otter_muldiv_pkg;

    localparam int XLEN = 32;
    localparam int CW   = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF_DIVIDEND  =
        {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic is_div(muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic a_signed(muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/otter_muldiv_if.sv
// otter_muldiv_if: request/response bundle between the
// execute stage and the multiply/divide unit.
interface otter_muldiv_if;
    import otter_muldiv_pkg::*;

    logic            START;
    logic [2:0]      FUNCT3;
    logic [XLEN-1:0] SRC_A;
    logic [XLEN-1:0] SRC_B;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    modport master (
        output START, FUNCT3, SRC_A, SRC_B,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, FUNCT3, SRC_A, SRC_B,
        output BUSY, DONE, RESULT
    );

endinterface

// File: rtl/otter_muldiv.sv
// otter_muldiv: iterative shift-add multiplier and restoring
// divider sharing one accumulator, counter and FSM.
module otter_muldiv
    import otter_muldiv_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    otter_muldiv_if.slave bus
);

    state_t            r_state;
    muldiv_op_t        r_op;
    logic [CW-1:0]     r_cnt;
    logic              r_sa;
    logic              r_sb;
    logic [XLEN-1:0]   r_mb;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;
    logic              r_done;

    muldiv_op_t        w_op;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic              w_dz;
    logic              w_ovf;
    logic [XLEN:0]     w_msum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_trial;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_new;
    logic [2*XLEN-1:0] w_div_next;
    logic              w_neg;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fin;

    // Operand decode: signs, magnitudes and the divide short-cuts.
    assign w_op  = muldiv_op_t'(bus.FUNCT3);
    assign w_sa  = a_signed(w_op) & bus.SRC_A[XLEN-1];
    assign w_sb  = b_signed(w_op) & bus.SRC_B[XLEN-1];
    assign w_ma  = w_sa ? -bus.SRC_A : bus.SRC_A;
    assign w_mb  = w_sb ? -bus.SRC_B : bus.SRC_B;
    assign w_dz  = is_div(w_op) && (bus.SRC_B == '0);
    assign w_ovf = (w_op == OP_DIV || w_op == OP_REM)
                && (bus.SRC_A == OVF_DIVIDEND)
                && (bus.SRC_B == {XLEN{1'b1}});

    // Multiply step: add multiplicand to the high half, shift right.
    assign w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                  + (r_acc[0] ? {1'b0, r_mb} : '0);
    assign w_mul_next = {w_msum, r_acc[XLEN-1:1]};

    // Divide step: high half is the partial remainder, low half
    // shifts the dividend out and the quotient bits in.
    assign w_trial    = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge       = w_trial >= {1'b0, r_mb};
    assign w_rem_new  = w_ge ? XLEN'(w_trial - {1'b0, r_mb})
                             : w_trial[XLEN-1:0];
    assign w_div_next = {w_rem_new, r_acc[XLEN-2:0], w_ge};

    // Sign correction on the magnitude results.
    assign w_neg  = r_sa ^ r_sb;
    assign w_prod = w_neg ? -r_acc : r_acc;
    assign w_quo  = w_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN]
                         : r_acc[2*XLEN-1:XLEN];

    // Select the architectural result for the latched opcode.
    always_comb begin
        w_fin = w_rem;
        case (r_op)
            OP_MUL:                      w_fin = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fin = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             w_fin = w_quo;
            default:                     w_fin = w_rem;
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.START) begin
                        r_op  <= w_op;
                        r_cnt <= '0;
                        r_mb  <= w_mb;
                        if (w_dz) begin
                            r_sa    <= 1'b0;
                            r_sb    <= 1'b0;
                            r_acc   <= {bus.SRC_A, DIV_BY_ZERO_Q};
                            r_state <= FINISH;
                        end else if (w_ovf) begin
                            r_sa    <= 1'b0;
                            r_sb    <= 1'b0;
                            r_acc   <= {{XLEN{1'b0}}, OVF_DIVIDEND};
                            r_state <= FINISH;
                        end else begin
                            r_sa    <= w_sa;
                            r_sb    <= w_sb;
                            r_acc   <= {{XLEN{1'b0}}, w_ma};
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc <= is_div(r_op) ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(XLEN - 1)) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_result <= w_fin;
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.BUSY   = (r_state != IDLE);
    assign bus.DONE   = r_done;
    assign bus.RESULT = r_result;

endmodule

// File: tb/tb_otter_muldiv.sv
// tb_otter_muldiv: directed vectors with a result scoreboard
// checked by an independent DONE monitor.
module tb_otter_muldiv;
    import otter_muldiv_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   done_cnt;

    logic [31:0] exp_q[$];
    string       name_q[$];

    otter_muldiv_if mif();

    otter_muldiv dut (
        .CLK (clk),
        .RST (rst),
        .bus (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: pop and compare one expected result per DONE pulse.
    always @(negedge clk) begin
        if (!rst && mif.DONE) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got 0x%08h expected none",
                         mif.RESULT);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string n = name_q.pop_front();
                if (mif.RESULT !== e) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h",
                             n, mif.RESULT, e);
                end
            end
        end
    end

    // Caller sits at #1 after a rising edge.
    task automatic wait_idle();
        int k;
        k = 0;
        while (mif.BUSY && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (mif.BUSY) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e,
                       input int lat, input string nm);
        int k;
        int bz;
        wait_idle();
        mif.START  = 1'b1;
        mif.FUNCT3 = f;
        mif.SRC_A  = a;
        mif.SRC_B  = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;
        mif.START  = 1'b0;
        mif.FUNCT3 = 3'($urandom);
        mif.SRC_A  = $urandom;
        mif.SRC_B  = $urandom;
        k  = 0;
        bz = 0;
        while (!mif.DONE && k < 100) begin
            if (mif.BUSY) bz++;
            @(posedge clk); #1;
            k++;
        end
        check({nm, "_lat"}, k, lat);
        check({nm, "_busy"}, bz, lat);
    endtask

    initial begin
        int d0;
        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        rst        = 1'b1;
        mif.START  = 1'b0;
        mif.FUNCT3 = 3'd0;
        mif.SRC_A  = '0;
        mif.SRC_B  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", mif.BUSY, 1'b0);
        check("rst_done", mif.DONE, 1'b0);
        check("rst_result", mif.RESULT, 32'd0);

        run(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        run(3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33, "mulhu");
        run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
        run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
        run(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu");
        run(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu");
        run(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_z");
        run(3'b110, 32'd5, 32'd0, 32'd5, 1, "rem_z");
        run(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_z");
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

        // START during CALC and during FINISH is ignored.
        wait_idle();
        d0 = done_cnt;
        mif.START  = 1'b1;
        mif.FUNCT3 = 3'b000;
        mif.SRC_A  = 32'd5;
        mif.SRC_B  = 32'd6;
        exp_q.push_back(32'd30);
        name_q.push_back("ign_first");
        @(posedge clk); #1;
        mif.START = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        mif.START  = 1'b1;
        mif.FUNCT3 = 3'b101;
        mif.SRC_A  = 32'd9;
        mif.SRC_B  = 32'd3;
        @(posedge clk); #1;
        mif.START = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        mif.START = 1'b1;
        @(posedge clk); #1;
        check("ign_done_edge", mif.DONE, 1'b1);
        mif.FUNCT3 = 3'b000;
        mif.SRC_A  = 32'd2;
        mif.SRC_B  = 32'd3;
        exp_q.push_back(32'd6);
        name_q.push_back("ign_next");
        @(posedge clk); #1;
        mif.START = 1'b0;
        check("ign_accept", mif.BUSY, 1'b1);
        wait_idle();
        @(negedge clk);
        check("ign_done_count", done_cnt - d0, 2);
        @(posedge clk); #1;

        // Reset in the middle of CALC aborts without DONE.
        d0 = done_cnt;
        mif.START  = 1'b1;
        mif.FUNCT3 = 3'b000;
        mif.SRC_A  = 32'h1234;
        mif.SRC_B  = 32'h5678;
        @(posedge clk); #1;
        mif.START = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", mif.BUSY, 1'b0);
        check("abort_result", mif.RESULT, 32'd0);
        check("abort_done", mif.DONE, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        run(3'b000, 32'd3, 32'd4, 32'd12, 33, "mul_after_rst");

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
